// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: register map, status bits, FSM states.
package ps2_pkg;

    // Word addresses on the register bus
    localparam logic [31:0] ADDR_TXDATA = 32'd0;
    localparam logic [31:0] ADDR_STATUS = 32'd1;

    // STATUS register bit positions
    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_DONE     = 1;
    localparam int unsigned STAT_NACK     = 2;
    localparam int unsigned STAT_TIMEOUT  = 3;
    localparam int unsigned STAT_OVERRUN  = 4;

    // Transmit frame sequencing
    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StShift,
        StAck,
        StRecover
    } tx_state_e;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizer plus falling-edge detector for one asynchronous PS/2 pin.
module ps2_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2  // must be at least 2
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Pin,
    output logic o_Level,
    output logic o_Fe
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    // Shift the pin through the synchronizer chain; remember the previous synced level
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_Pin};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset to 1 (idle bus level) so leaving reset never looks like a falling edge
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Falling edge: synced 1 followed by synced 0
    always_comb begin
        o_Level = sync_q[SYNC_STAGES-1];
        o_Fe    = prev_q & ~sync_q[SYNC_STAGES-1];
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift a byte on device clocks.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned REQ_CYCLES     = 200,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Ps2Clk,
    input  logic        i_Ps2Sda,
    output logic        o_Ps2ClkOe,
    output logic        o_Ps2SdaOe,
    input  logic        i_WEnable,
    input  logic [31:0] i_WAddr,
    input  logic [31:0] i_WData,
    input  logic        i_REnable,
    input  logic [31:0] i_RAddr,
    output logic [31:0] o_RData,
    output logic        o_Err
);

    logic ps2_clk_level, ps2_clk_fe;
    logic ps2_sda_level, ps2_sda_fe;

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_clk (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Pin  (i_Ps2Clk),
        .o_Level(ps2_clk_level),
        .o_Fe   (ps2_clk_fe)
    );

    ps2_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_sda (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_Pin  (i_Ps2Sda),
        .o_Level(ps2_sda_level),
        .o_Fe   (ps2_sda_fe)
    );

    tx_state_e   state_q, state_d;
    logic [31:0] tmr_q, tmr_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [8:0]  frame_q, frame_d;      // {parity, data}
    logic [7:0]  txdata_q, txdata_d;
    logic        clk_oe_q, clk_oe_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic        timeout_q, timeout_d;
    logic        overrun_q, overrun_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] status;
    logic        wr_tx, wr_status;

    logic unused_wdata;
    assign unused_wdata = ^{i_WData[31:8], ps2_sda_fe};

    always_comb begin
        wr_tx     = i_WEnable && (i_WAddr == ADDR_TXDATA);
        wr_status = i_WEnable && (i_WAddr == ADDR_STATUS);
    end

    // Assemble the STATUS word from the flag registers
    always_comb begin
        status               = '0;
        status[STAT_BUSY]    = busy_q;
        status[STAT_DONE]    = done_q;
        status[STAT_NACK]    = nack_q;
        status[STAT_TIMEOUT] = timeout_q;
        status[STAT_OVERRUN] = overrun_q;
    end

    // Frame sequencing, timers and flag updates
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        txdata_d  = txdata_q;
        clk_oe_d  = clk_oe_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        done_d    = done_q;
        nack_d    = nack_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;

        // W1C is applied first so that any flag set below in the same cycle wins
        if (wr_status) begin
            if (i_WData[STAT_DONE])     done_d    = 1'b0;
            if (i_WData[STAT_NACK])     nack_d    = 1'b0;
            if (i_WData[STAT_TIMEOUT])  timeout_d = 1'b0;
            if (i_WData[STAT_OVERRUN])  overrun_d = 1'b0;
        end

        if (wr_tx && busy_q) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                clk_oe_d = 1'b0;
                sda_oe_d = 1'b0;
                if (wr_tx) begin
                    txdata_d = i_WData[7:0];
                    frame_d  = {odd_parity(i_WData[7:0]), i_WData[7:0]};
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    tmr_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = StInhibit;
                end
            end

            StInhibit: begin
                tmr_d = tmr_q + 32'd1;
                if (tmr_q == INHIBIT_CYCLES - 1) begin
                    tmr_d    = '0;
                    sda_oe_d = 1'b1;
                    state_d  = StReq;
                end
            end

            StReq: begin
                tmr_d = tmr_q + 32'd1;
                if (tmr_q == REQ_CYCLES - 1) begin
                    // Releasing the clock with data held low is the start bit
                    tmr_d     = '0;
                    clk_oe_d  = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = StShift;
                end
            end

            StShift: begin
                tmr_d = tmr_q + 32'd1;
                if (ps2_clk_fe) begin
                    tmr_d = '0;
                    if (bit_cnt_q == 4'd9) begin
                        sda_oe_d = 1'b0;  // stop bit is a released line
                        state_d  = StAck;
                    end else begin
                        sda_oe_d  = ~frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end

            StAck: begin
                tmr_d = tmr_q + 32'd1;
                if (ps2_clk_fe) begin
                    tmr_d = '0;
                    if (ps2_sda_level) begin
                        nack_d = 1'b1;
                    end
                    state_d = StRecover;
                end
            end

            StRecover: begin
                tmr_d = tmr_q + 32'd1;
                if (ps2_clk_fe) begin
                    tmr_d = '0;
                end
                if (ps2_clk_level && ps2_sda_level) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end

            default: begin
                clk_oe_d = 1'b0;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = StIdle;
            end
        endcase

        // A device that stops clocking must not hang the transmitter
        if ((state_q == StShift || state_q == StAck || state_q == StRecover) &&
            !ps2_clk_fe && (tmr_q >= TIMEOUT_CYCLES - 1)) begin
            clk_oe_d  = 1'b0;
            sda_oe_d  = 1'b0;
            timeout_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            state_d   = StIdle;
        end
    end

    // Error summary lags the flags by one cycle
    always_comb begin
        err_d = nack_q | timeout_q | overrun_q;
    end

    // Registered read port; holds its value while no read is requested
    always_comb begin
        rdata_d = rdata_q;
        if (i_REnable) begin
            if (i_RAddr == ADDR_TXDATA) begin
                rdata_d = {24'd0, txdata_q};
            end else if (i_RAddr == ADDR_STATUS) begin
                rdata_d = status;
            end else begin
                rdata_d = '0;
            end
        end
    end

    // State and register file; reset releases the bus immediately
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            txdata_q  <= '0;
            clk_oe_q  <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            txdata_q  <= txdata_d;
            clk_oe_q  <= clk_oe_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        o_Ps2ClkOe = clk_oe_q;
        o_Ps2SdaOe = sda_oe_q;
        o_RData    = rdata_q;
        o_Err      = err_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device on the bus.
module tb_ps2_host_tx;

    localparam int unsigned INH  = 40;
    localparam int unsigned REQ  = 8;
    localparam int unsigned TMO  = 500;
    localparam int          HALF = 25;   // device clock half period in system cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wen = 1'b0, ren = 1'b0;
    logic [31:0] waddr = '0, wdata = '0, raddr = '0;
    logic        clk_oe, sda_oe, err;
    logic [31:0] rdata;
    logic        dev_clk_low = 1'b0, dev_sda_low = 1'b0;
    logic        bus_clk, bus_sda;

    assign bus_clk = !(clk_oe || dev_clk_low);
    assign bus_sda = !(sda_oe || dev_sda_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES   (2)
    ) dut (
        .i_Clk     (clk),
        .i_Rst     (rst),
        .i_Ps2Clk  (bus_clk),
        .i_Ps2Sda  (bus_sda),
        .o_Ps2ClkOe(clk_oe),
        .o_Ps2SdaOe(sda_oe),
        .i_WEnable (wen),
        .i_WAddr   (waddr),
        .i_WData   (wdata),
        .i_REnable (ren),
        .i_RAddr   (raddr),
        .o_RData   (rdata),
        .o_Err     (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic       m_done = 0, m_nack = 0, m_to = 0, m_ovr = 0;
    logic [7:0] m_txdata = 8'h00;

    function automatic logic [31:0] model_status();
        return {27'd0, m_ovr, m_to, m_nack, m_done, 1'b0};
    endfunction

    function automatic logic model_err();
        return m_nack | m_to | m_ovr;
    endfunction

    // Bits as the device should see them, in order: D0..D7, parity, stop
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b};
    endfunction

    function automatic void model_w1c(input logic [31:0] m);
        if (m[1]) m_done = 0;
        if (m[2]) m_nack = 0;
        if (m[3]) m_to   = 0;
        if (m[4]) m_ovr  = 0;
    endfunction

    // ---------------- scoreboard queues ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } rd_exp_t;

    logic [9:0] exp_frame_q[$];
    rd_exp_t    exp_rd_q[$];

    // ---------------- bus tasks ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wen = 1'b1; waddr = a; wdata = d;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic bus_read_expect(input logic [31:0] a);
        rd_exp_t e;
        e.addr = a;
        e.err  = model_err();
        if (a == 32'd0)      e.data = {24'd0, m_txdata};
        else if (a == 32'd1) e.data = model_status();
        else                 e.data = '0;
        @(posedge clk); #1;
        ren = 1'b1; raddr = a;
        exp_rd_q.push_back(e);
        @(posedge clk); #1;
        ren = 1'b0;
    endtask

    // Read monitor: data is valid the cycle after the strobe
    logic rd_vld = 1'b0;
    always @(posedge clk) rd_vld <= ren;

    initial begin : read_monitor
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (exp_rd_q.size() == 0) begin
                    check("read_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_rd_q.pop_front();
                    check($sformatf("rdata[addr=%0d]", e.addr), rdata, e.data);
                    check($sformatf("err[addr=%0d]", e.addr), {31'd0, err}, {31'd0, e.err});
                end
            end
        end
    end

    // Inhibit / request duration monitor
    initial begin : oe_monitor
        int inh_cnt = 0;
        int req_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                inh_cnt = 0; req_cnt = 0;
            end else if (clk_oe && !sda_oe) begin
                inh_cnt++;
            end else if (clk_oe && sda_oe) begin
                if (inh_cnt > 0) begin
                    check("inhibit_len", inh_cnt, INH);
                    inh_cnt = 0;
                end
                req_cnt++;
            end else begin
                if (req_cnt > 0) check("req_len", req_cnt, REQ);
                inh_cnt = 0; req_cnt = 0;
            end
        end
    end

    // ---------------- device model ----------------
    logic       dev_ack = 1'b1;
    int         dev_edge_limit = 11;
    logic       dev_abort = 1'b0;
    logic       dev_busy = 1'b0;
    int         dev_edges = 0;
    int         dev_done_cnt = 0;
    logic       dev_ab = 1'b0, dev_clk_seen = 1'b0;
    logic [9:0] obs;

    task dev_wait(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (dev_abort) dev_ab = 1'b1;
            if (clk_oe)    dev_clk_seen = 1'b1;
        end
    endtask

    initial begin : device
        logic armed;
        logic [9:0] e;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (clk_oe) armed = 1'b1;
            if (armed && !rst && !dev_abort && !clk_oe && bus_clk && !bus_sda) begin
                armed = 1'b0; dev_busy = 1'b1; dev_edges = 0;
                dev_ab = 1'b0; dev_clk_seen = 1'b0; obs = '0;
                dev_wait(HALF);
                for (int k = 1; k <= 11; k++) begin
                    if (dev_ab || k > dev_edge_limit) break;
                    if (k == 11) begin
                        if (dev_ack) dev_sda_low = 1'b1;
                        dev_wait(5);
                    end
                    dev_clk_low = 1'b1; dev_edges = k;
                    dev_wait(HALF);
                    dev_clk_low = 1'b0;
                    if (k <= 10) obs[k-1] = bus_sda;
                    dev_wait(HALF);
                    dev_sda_low = 1'b0;
                end
                dev_clk_low = 1'b0; dev_sda_low = 1'b0;
                if (!dev_ab && dev_edges == 11) begin
                    if (exp_frame_q.size() == 0) begin
                        check("frame_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_frame_q.pop_front();
                        check("frame_bits", {22'd0, obs}, {22'd0, e});
                    end
                    check("clk_driven_in_shift", {31'd0, dev_clk_seen}, 32'd0);
                end
                dev_done_cnt++;
                dev_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_frame(input logic [7:0] b, input logic ack, input int limit,
                               input logic full);
        dev_ack = ack;
        dev_edge_limit = limit;
        if (full) exp_frame_q.push_back(model_frame(b));
        m_done = 0;
        m_txdata = b;
        bus_write(32'd0, {24'd0, b});
    endtask

    task automatic wait_dev_done(input int prev);
        int t = 0;
        while (dev_done_cnt == prev && t < 5000) begin
            @(posedge clk); t++;
        end
        check("frame_end_seen", {31'd0, dev_done_cnt != prev}, 32'd1);
        repeat (15) @(posedge clk);
    endtask

    task automatic wait_edges(input int n);
        int t = 0;
        while (dev_edges < n && t < 5000) begin
            @(posedge clk); t++;
        end
        check("edges_reached", {31'd0, dev_edges >= n}, 32'd1);
    endtask

    task automatic clear_all();
        bus_write(32'd1, 32'h1E);
        model_w1c(32'h1E);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int prev;
        logic [7:0] b;
        logic ack;
        logic [31:0] mask;

        repeat (3) @(posedge clk);
        #1;
        check("reset_clk_oe", {31'd0, clk_oe}, 32'd0);
        check("reset_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("reset_err", {31'd0, err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        bus_read_expect(32'd1);

        // LED-set command, acked
        prev = dev_done_cnt;
        start_frame(8'hED, 1'b1, 11, 1'b1);
        wait_dev_done(prev);
        m_done = 1;
        bus_read_expect(32'd1);
        bus_read_expect(32'd0);

        // No ack from device
        prev = dev_done_cnt;
        start_frame(8'h00, 1'b0, 11, 1'b1);
        wait_dev_done(prev);
        m_done = 1; m_nack = 1;
        bus_read_expect(32'd1);
        bus_write(32'd1, 32'h4);
        model_w1c(32'h4);
        bus_read_expect(32'd1);

        // Random bytes with random ack and random W1C masks
        for (int k = 0; k < 6; k++) begin
            b    = 8'($urandom);
            ack  = ($urandom_range(0, 3) != 0);
            prev = dev_done_cnt;
            start_frame(b, ack, 11, 1'b1);
            wait_dev_done(prev);
            m_done = 1;
            if (!ack) m_nack = 1;
            bus_read_expect(32'd1);
            mask = $urandom & 32'h1F;
            bus_write(32'd1, mask);
            model_w1c(mask);
            bus_read_expect(32'd1);
        end

        // Device stops clocking after three edges
        clear_all();
        prev = dev_done_cnt;
        start_frame(8'hFF, 1'b1, 3, 1'b0);
        wait_dev_done(prev);
        repeat (TMO + 40) @(posedge clk);
        @(negedge clk);
        check("timeout_clk_oe", {31'd0, clk_oe}, 32'd0);
        check("timeout_sda_oe", {31'd0, sda_oe}, 32'd0);
        m_to = 1; m_done = 0;
        bus_read_expect(32'd1);

        // Write while busy is dropped and flagged
        clear_all();
        prev = dev_done_cnt;
        start_frame(8'hF4, 1'b1, 11, 1'b1);
        wait_edges(2);
        bus_write(32'd0, 32'h55);
        m_ovr = 1;
        wait_dev_done(prev);
        m_done = 1;
        bus_read_expect(32'd1);
        bus_read_expect(32'd0);

        // Reset in the middle of SHIFT
        clear_all();
        start_frame(8'($urandom), 1'b1, 11, 1'b0);
        wait_edges(4);
        dev_abort = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_clk_oe_async", {31'd0, clk_oe}, 32'd0);
        check("rst_sda_oe_async", {31'd0, sda_oe}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_done = 0; m_nack = 0; m_to = 0; m_ovr = 0; m_txdata = 8'h00;
        begin
            int t = 0;
            while (dev_busy && t < 1000) begin
                @(posedge clk); t++;
            end
            check("device_abort_seen", {31'd0, dev_busy}, 32'd0);
        end
        dev_abort = 1'b0;
        bus_read_expect(32'd1);
        bus_read_expect(32'd0);

        // Unmapped addresses
        bus_write(32'd5, 32'hFFFF_FFFF);
        bus_read_expect(32'd7);
        for (int k = 0; k < 4; k++) bus_read_expect(32'($urandom_range(2, 1000)));
        bus_read_expect(32'd1);

        repeat (5) @(posedge clk);
        check("frames_outstanding", exp_frame_q.size(), 32'd0);
        check("reads_outstanding", exp_rd_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
